// File: rtl/samp_seq.sv
// Sample/hold timing generator for the sampling switch; all outputs registered, enables lead seq_samp by one cycle.
// No backpressure: start is sampled only in IDLE, stop is honoured only at a period boundary.
module samp_seq #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] cfg_samp_len,
    input  logic [CNT_W-1:0] cfg_hold_len,
    input  logic [CNT_W-1:0] cfg_nconv,
    input  logic             cfg_p_en,
    input  logic             cfg_n_en,
    output logic             seq_samp,
    output logic             samp_p_en,
    output logic             samp_n_en,
    output logic             busy,
    output logic             conv_done,
    output logic [CNT_W-1:0] conv_cnt
);

    typedef enum logic [1:0] {IDLE, ARM, SAMP, HOLD} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] samp_len_q, samp_len_d;
    logic [CNT_W-1:0] hold_len_q, hold_len_d;
    logic [CNT_W-1:0] nconv_q, nconv_d;
    logic [CNT_W-1:0] conv_cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             seq_samp_d, samp_p_en_d, samp_n_en_d, busy_d, conv_done_d;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        samp_len_d  = samp_len_q;
        hold_len_d  = hold_len_q;
        nconv_d     = nconv_q;
        conv_cnt_d  = conv_cnt;
        seq_samp_d  = seq_samp;
        samp_p_en_d = samp_p_en;
        samp_n_en_d = samp_n_en;
        busy_d      = busy;
        conv_done_d = 1'b0;
        cnt_inc     = conv_cnt + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = ARM;
                    samp_len_d  = (cfg_samp_len == '0) ? CNT_W'(1) : cfg_samp_len;
                    hold_len_d  = (cfg_hold_len == '0) ? CNT_W'(1) : cfg_hold_len;
                    nconv_d     = cfg_nconv;
                    conv_cnt_d  = '0;
                    busy_d      = 1'b1;
                    samp_p_en_d = cfg_p_en;
                    samp_n_en_d = cfg_n_en;
                end
            end
            ARM: begin
                state_d    = SAMP;
                seq_samp_d = 1'b1;
                phase_d    = samp_len_q - CNT_W'(1);
            end
            SAMP: begin
                // phase counts down the remaining cycles of the current window
                if (phase_q == '0) begin
                    state_d    = HOLD;
                    seq_samp_d = 1'b0;
                    phase_d    = hold_len_q - CNT_W'(1);
                end else begin
                    phase_d = phase_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (phase_q == '0) begin
                    conv_done_d = 1'b1;
                    conv_cnt_d  = cnt_inc;
                    if (((nconv_q != '0) && (cnt_inc == nconv_q)) || stop) begin
                        state_d     = IDLE;
                        busy_d      = 1'b0;
                        samp_p_en_d = 1'b0;
                        samp_n_en_d = 1'b0;
                    end else begin
                        state_d    = SAMP;
                        seq_samp_d = 1'b1;
                        phase_d    = samp_len_q - CNT_W'(1);
                    end
                end else begin
                    phase_d = phase_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            samp_len_q <= '0;
            hold_len_q <= '0;
            nconv_q    <= '0;
            conv_cnt   <= '0;
            seq_samp   <= 1'b0;
            samp_p_en  <= 1'b0;
            samp_n_en  <= 1'b0;
            busy       <= 1'b0;
            conv_done  <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            samp_len_q <= samp_len_d;
            hold_len_q <= hold_len_d;
            nconv_q    <= nconv_d;
            conv_cnt   <= conv_cnt_d;
            seq_samp   <= seq_samp_d;
            samp_p_en  <= samp_p_en_d;
            samp_n_en  <= samp_n_en_d;
            busy       <= busy_d;
            conv_done  <= conv_done_d;
        end
    end

endmodule

// File: tb/tb_samp_seq.sv
// Bench for samp_seq: directed scenarios plus randomized inputs, checked against a period-arithmetic reference model.
module tb_samp_seq;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [CW-1:0] cfg_samp_len = '0;
    logic [CW-1:0] cfg_hold_len = '0;
    logic [CW-1:0] cfg_nconv = '0;
    logic          cfg_p_en = 1'b0;
    logic          cfg_n_en = 1'b0;
    logic          seq_samp, samp_p_en, samp_n_en, busy, conv_done;
    logic [CW-1:0] conv_cnt;

    samp_seq #(.CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .cfg_samp_len (cfg_samp_len),
        .cfg_hold_len (cfg_hold_len),
        .cfg_nconv    (cfg_nconv),
        .cfg_p_en     (cfg_p_en),
        .cfg_n_en     (cfg_n_en),
        .seq_samp     (seq_samp),
        .samp_p_en    (samp_p_en),
        .samp_n_en    (samp_n_en),
        .busy         (busy),
        .conv_done    (conv_done),
        .conv_cnt     (conv_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a burst is a cycle index k since the start edge;
    // cycle k>=1 sits at offset (k-1) mod (L+H) within its period.
    logic          m_on, m_seq, m_p, m_n, m_done;
    logic [CW-1:0] m_cnt;
    int            m_k, m_l, m_h, m_nconv;

    int done_pulses;
    int busy_cycles;

    task automatic model_reset();
        m_on = 0; m_seq = 0; m_p = 0; m_n = 0; m_done = 0; m_cnt = '0; m_k = 0;
    endtask

    task automatic model_step();
        int pos;
        if (rst) begin
            model_reset();
            return;
        end
        m_done = 0;
        if (!m_on) begin
            if (start) begin
                m_on    = 1;
                m_k     = 0;
                m_l     = (cfg_samp_len == 0) ? 1 : int'(cfg_samp_len);
                m_h     = (cfg_hold_len == 0) ? 1 : int'(cfg_hold_len);
                m_nconv = int'(cfg_nconv);
                m_cnt   = '0;
                m_seq   = 0;
                m_p     = cfg_p_en;
                m_n     = cfg_n_en;
            end
        end else begin
            m_k++;
            pos = (m_k - 1) % (m_l + m_h);
            if (m_k > 1 && pos == 0) begin
                m_cnt++;
                m_done = 1;
                if ((m_nconv != 0 && int'(m_cnt) == m_nconv) || stop) begin
                    m_on = 0; m_seq = 0; m_p = 0; m_n = 0;
                end else begin
                    m_seq = 1;
                end
            end else begin
                m_seq = (pos < m_l);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("seq_samp",  seq_samp,  m_seq);
        check("busy",      busy,      m_on);
        check("samp_p_en", samp_p_en, m_p);
        check("samp_n_en", samp_n_en, m_n);
        check("conv_done", conv_done, m_done);
        check("conv_cnt",  conv_cnt,  m_cnt);
        if (conv_done) done_pulses++;
        if (busy) busy_cycles++;
    endtask

    task automatic set_cfg(input int l, input int h, input int n, input logic p, input logic ne);
        cfg_samp_len = CW'(l);
        cfg_hold_len = CW'(h);
        cfg_nconv    = CW'(n);
        cfg_p_en     = p;
        cfg_n_en     = ne;
    endtask

    task automatic begin_burst();
        done_pulses = 0;
        busy_cycles = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    initial begin
        model_reset();
        done_pulses = 0;
        busy_cycles = 0;

        rst = 1'b1;
        #2;
        check("rst_seq_samp", seq_samp, 0);
        check("rst_busy", busy, 0);
        check("rst_conv_cnt", conv_cnt, 0);
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // Basic burst L=3 H=5 N=2
        set_cfg(3, 5, 2, 1'b1, 1'b1);
        begin_burst();
        run_until_idle(40);
        check("basic_cnt", conv_cnt, 2);
        check("basic_done", done_pulses, 2);
        check("basic_busy_cycles", busy_cycles, 17);
        repeat (2) tick();

        // Zero lengths behave as 1
        set_cfg(0, 0, 3, 1'b1, 1'b0);
        begin_burst();
        run_until_idle(40);
        check("zero_cnt", conv_cnt, 3);
        check("zero_done", done_pulses, 3);
        check("zero_busy_cycles", busy_cycles, 7);
        tick();

        // Continuous, stop raised in first SAMP cycle of the 4th period
        set_cfg(2, 2, 0, 1'b0, 1'b1);
        begin_burst();
        repeat (13) tick();
        stop = 1'b1;
        run_until_idle(40);
        stop = 1'b0;
        check("stop_cnt", conv_cnt, 4);
        check("stop_done", done_pulses, 4);
        repeat (3) tick();
        check("cnt_hold_after_burst", conv_cnt, 4);

        // Enable ordering with mid-burst config changes and start re-pulse
        set_cfg(2, 3, 2, 1'b1, 1'b0);
        begin_burst();
        tick();
        set_cfg(7, 1, 1, 1'b0, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_until_idle(40);
        check("order_done", done_pulses, 2);
        check("order_busy_cycles", busy_cycles, 11);
        tick();

        // Async reset in the middle of SAMP
        set_cfg(4, 2, 3, 1'b1, 1'b1);
        begin_burst();
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        check("arst_seq_samp", seq_samp, 0);
        check("arst_p_en", samp_p_en, 0);
        check("arst_n_en", samp_n_en, 0);
        check("arst_busy", busy, 0);
        model_reset();
        tick();
        rst = 1'b0;
        tick();
        set_cfg(1, 1, 1, 1'b1, 1'b0);
        begin_burst();
        check("post_rst_cnt0", conv_cnt, 0);
        run_until_idle(20);
        check("post_rst_cnt", conv_cnt, 1);
        tick();

        // Counter wrap: 17 periods of L=H=1 then stop
        set_cfg(1, 1, 0, 1'b0, 1'b0);
        begin_burst();
        repeat (33) tick();
        stop = 1'b1;
        run_until_idle(10);
        stop = 1'b0;
        check("wrap_cnt", conv_cnt, 1);
        check("wrap_done", done_pulses, 17);
        tick();

        // Random inputs every cycle, including held start and random stop
        for (int i = 0; i < 3000; i++) begin
            start        = ($urandom_range(0, 3) == 0);
            stop         = ($urandom_range(0, 7) == 0);
            cfg_samp_len = CW'($urandom_range(0, 4));
            cfg_hold_len = CW'($urandom_range(0, 4));
            cfg_nconv    = CW'($urandom_range(0, 4));
            cfg_p_en     = 1'($urandom_range(0, 1));
            cfg_n_en     = 1'($urandom_range(0, 1));
            tick();
        end
        start = 1'b0;
        stop  = 1'b1;
        run_until_idle(40);
        stop = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/samp_seq.md
Name: samp_seq

Overview:
- Timing generator on the driving side of the sampling-switch control path.
- Produces `seq_samp` plus the stable `samp_p_en` / `samp_n_en` enables consumed by the switch-control gating logic.
- Runs bursts of N conversion periods, or runs continuously. Each period is a programmable sample window followed by a programmable hold/convert window.
- Sits between the chip-level control registers and the sampling switch drivers.

Parameters:
- CNT_W, 8, width of the length/count config fields and of `conv_cnt`.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a burst; sampled only in IDLE.
- stop  in  1  level; request a graceful end of the burst.
- cfg_samp_len  in  CNT_W  `seq_samp` high time in cycles; 0 is treated as 1.
- cfg_hold_len  in  CNT_W  low/convert time per period in cycles; 0 is treated as 1.
- cfg_nconv  in  CNT_W  conversions per burst; 0 means continuous until `stop`.
- cfg_p_en  in  1  drive P-side switch during the burst.
- cfg_n_en  in  1  drive N-side switch during the burst.
- seq_samp  out  1  sampling phase signal.
- samp_p_en  out  1  P-side enable, stable for the whole burst.
- samp_n_en  out  1  N-side enable, stable for the whole burst.
- busy  out  1  high from ARM through the last HOLD cycle.
- conv_done  out  1  one-cycle pulse per completed period.
- conv_cnt  out  CNT_W  completed conversions in the current/last burst.

Behaviour:
- Reset (asynchronous, immediate): all outputs 0, state IDLE, internal counters 0. Applies mid-burst too; `seq_samp` and the enables drop without waiting for a clock.
- All outputs are registered; no combinational paths from inputs to outputs.
- States: IDLE, ARM, SAMP, HOLD.
- IDLE:
  - `start`=1 at an edge → ARM.
  - Same edge: latch all `cfg_*` (lengths with 0→1 substitution), clear `conv_cnt`, set `busy`=1, `samp_p_en`=`cfg_p_en`, `samp_n_en`=`cfg_n_en`.
  - Config changes during a burst are ignored.
- ARM: exactly 1 cycle → SAMP; `seq_samp` goes 1 on that edge. The enables therefore lead the `seq_samp` rise by one cycle, so the downstream gating never glitches.
- SAMP:
  - `seq_samp`=1 for exactly L = latched `samp_len` cycles.
  - On the last SAMP cycle edge → HOLD, `seq_samp`=0.
- HOLD:
  - `seq_samp`=0 for exactly H = latched `hold_len` cycles.
  - On the last HOLD edge: `conv_done`=1 for one cycle and `conv_cnt` increments.
  - Next state is IDLE if either condition holds: `nconv`≠0 and the incremented count equals `nconv`; or `stop` is sampled high at that edge.
  - Otherwise next state is SAMP, with `seq_samp`=1 on the same edge.
  - On entering IDLE on that edge: `busy`=0, `samp_p_en`=0, `samp_n_en`=0. The enables fall while `seq_samp` is already low.
- Period = L+H cycles; back-to-back periods have no gap.
- `stop`:
  - Never truncates SAMP or HOLD.
  - Evaluated only at the HOLD→next decision edge.
  - `stop` asserted in IDLE or ARM has no effect until that edge.
- `start` while not IDLE: ignored.
- `start` and `stop` both high in IDLE: burst starts; `stop` is honoured at the end of the first period (one conversion).
- `conv_cnt`:
  - Holds its value after the burst until the next `start`.
  - In continuous mode it wraps modulo 2^CNT_W; wrapping does not end the burst.
- `cfg_p_en`=`cfg_n_en`=0: the sequence still runs normally with both enables 0.
- `start` pulse width is irrelevant; a level held high restarts a new burst on the edge after the return to IDLE. That gives one idle cycle, with `busy`=0 for one cycle.

Test Plan:
- Basic burst: L=3, H=5, N=2, `start` at edge E0 → ARM after E0 (enables high); `seq_samp` high after E1..E3 and after E9..E11; `conv_done` after E9 and E17; IDLE/`busy`=0/enables 0 after E17; `conv_cnt`=2.
- Zero lengths: L=0, H=0, N=3 → `seq_samp` alternates 1,0 with period 2; 3 `conv_done` pulses; `conv_cnt`=3; `busy` high for 7 cycles.
- Continuous with stop: N=0, L=2, H=2, `stop` raised mid-SAMP of the 4th period → that period completes; IDLE after its HOLD; `conv_cnt`=4; `seq_samp` never truncated.
- Enable ordering: `cfg_p_en`=1, `cfg_n_en`=0, mid-burst `cfg` changes and a `start` re-pulse → `samp_p_en` rises 1 cycle before the first `seq_samp` rise and falls ≥H cycles after the last `seq_samp` fall; `samp_n_en` stays 0; timing unaffected by the mid-burst changes.
- Async reset mid-SAMP: `rst` asserted between edges → `seq_samp`, enables and `busy` go 0 immediately; after release, a new `start` runs a clean burst with `conv_cnt` starting at 0.
- Wrap: CNT_W=4, N=0, L=H=1, run 17 periods then `stop` → `conv_cnt`=1 (wrapped) and 17 `conv_done` pulses counted.
